// File: rtl/serial_tx_arb.sv
// serial_tx_arb
// Round-robin arbiter that lets NREQ requesters share one DW-bit serial
// transmitter. One word is accepted from the winning requester over a
// valid/ready handshake. The word is presented on tx_data_in/tx_valid_in until
// the transmitter reports busy. No new grant is made until busy falls again.
// If busy never comes, the word is dropped after TIMEOUT cycles.
//
// Ports:
//   clk          clock, all state on the rising edge
//   rst          asynchronous reset, active low
//   req_valid    per-requester word available
//   req_data     requester i word at bits [i*DW +: DW]
//   req_ready    one-hot accept, only in IDLE while the transmitter is free
//   tx_data_in   latched word to the transmitter (holds outside ISSUE)
//   tx_valid_in  word valid to the transmitter (high only in ISSUE)
//   tx_busy_out  transmitter busy
//   grant_id     index of the current or last granted requester
//   err_timeout  one-cycle pulse after an ISSUE abort

module serial_tx_arb #(
  parameter int NREQ    = 4,
  parameter int DW      = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*DW-1:0]      req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic [DW-1:0]           tx_data_in,
  output logic                    tx_valid_in,
  input  logic                    tx_busy_out,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    err_timeout
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   rrPtr_q, rrPtr_d;
  logic [IW-1:0]   grantId_q, grantId_d;
  logic [DW-1:0]   data_q, data_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;

  logic [IW-1:0]   winner;
  logic            found;
  logic [IW-1:0]   nextPtr;
  int              scanIdx;

  // Round-robin search: walk the requesters starting at rrPtr_q and keep the
  // first one that is valid. The index wraps by subtraction rather than modulo.
  always_comb begin
    winner  = '0;
    found   = 1'b0;
    scanIdx = 0;
    for (int k = 0; k < NREQ; k++) begin
      scanIdx = int'(rrPtr_q) + k;
      if (scanIdx >= NREQ) begin
        scanIdx = scanIdx - NREQ;
      end
      if (!found && req_valid[scanIdx]) begin
        found  = 1'b1;
        winner = IW'(scanIdx);
      end
    end
  end

  // Priority after a job ends moves to the requester after the one just
  // served, wrapping from NREQ-1 back to 0.
  always_comb begin
    if (grantId_q == IW'(NREQ - 1)) begin
      nextPtr = '0;
    end else begin
      nextPtr = grantId_q + IW'(1);
    end
  end

  // Next-state and output decode. req_ready is also gated by rst so that no
  // accept can appear while reset is held, even though the state is IDLE then.
  always_comb begin
    state_d     = state_q;
    rrPtr_d     = rrPtr_q;
    grantId_d   = grantId_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    err_d       = 1'b0;
    req_ready   = '0;
    tx_valid_in = 1'b0;

    case (state_q)
      IDLE: begin
        if (rst && !tx_busy_out && found) begin
          req_ready[winner] = 1'b1;
          data_d            = req_data[int'(winner)*DW +: DW];
          grantId_d         = winner;
          cnt_d             = '0;
          state_d           = ISSUE;
        end
      end

      ISSUE: begin
        tx_valid_in = 1'b1;
        if (tx_busy_out) begin
          state_d = BUSY;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          // The transmitter never took the word, so drop it and move on.
          err_d   = 1'b1;
          rrPtr_d = nextPtr;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      BUSY: begin
        if (!tx_busy_out) begin
          rrPtr_d = nextPtr;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers, cleared asynchronously when rst goes low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      rrPtr_q   <= '0;
      grantId_q <= '0;
      data_q    <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rrPtr_q   <= rrPtr_d;
      grantId_q <= grantId_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  assign tx_data_in  = data_q;
  assign grant_id    = grantId_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_serial_tx_arb.sv
// tb_serial_tx_arb
// Directed scenarios and randomized traffic for serial_tx_arb. A small
// transmitter model drives tx_busy_out, and the requesters are driven from
// the main initial block. A job-level reference model predicts accepts, the
// issue window, timeouts and the latched word/id every cycle.

module tb_serial_tx_arb;

  localparam int NREQ    = 4;
  localparam int DW      = 4;
  localparam int TIMEOUT = 15;
  localparam int IW      = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*DW-1:0]   req_data;
  logic [NREQ-1:0]      req_ready;
  logic [DW-1:0]        tx_data_in;
  logic                 tx_valid_in;
  logic                 tx_busy_out;
  logic [IW-1:0]        grant_id;
  logic                 err_timeout;

  serial_tx_arb #(
    .NREQ    (NREQ),
    .DW      (DW),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .tx_data_in  (tx_data_in),
    .tx_valid_in (tx_valid_in),
    .tx_busy_out (tx_busy_out),
    .grant_id    (grant_id),
    .err_timeout (err_timeout)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [DW-1:0] reqWord [NREQ];
  bit            holdValid;

  bit            txAlive;
  bit            forceBusy;
  int            busyLen;
  int            busyLeft;
  logic [DW-1:0] txLog [$];
  int            grantLog [$];

  bit            jobOpen;
  bit            awaitBusy;
  int            issueAge;
  int            rrNext;
  int            lastId;
  logic [DW-1:0] lastWord;
  bit            errExp;

  int            validHigh;
  int            errCount;
  int            readyCycles;

  // Single comparison point: counts the test and reports any failure.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Round-robin choice: first valid requester at or after 'start', wrapping.
  function automatic int pickWinner(input logic [NREQ-1:0] v, input int start);
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (start + k) % NREQ;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic modelReset();
    jobOpen   = 1'b0;
    awaitBusy = 1'b0;
    issueAge  = 0;
    rrNext    = 0;
    lastId    = 0;
    lastWord  = '0;
    errExp    = 1'b0;
  endtask

  task automatic setReq(input int i, input logic [DW-1:0] d);
    reqWord[i]            = d;
    req_data[i*DW +: DW]  = d;
    req_valid[i]          = 1'b1;
  endtask

  // One clock cycle: compare all outputs with the model, clock, then advance
  // the model, the transmitter model and the requesters.
  task automatic applyStimulus();
    logic [NREQ-1:0] v;
    logic [NREQ-1:0] hs;
    logic [NREQ-1:0] expReady;
    logic [DW-1:0]   txW;
    bit              busy;
    bit              txAcc;
    int              w;
    #1;
    v    = req_valid;
    busy = tx_busy_out;
    w    = (!jobOpen && !busy) ? pickWinner(v, rrNext) : -1;
    expReady = '0;
    if (w >= 0) expReady[w] = 1'b1;
    checkOutput("req_ready", req_ready, expReady);
    checkOutput("tx_valid_in", tx_valid_in, jobOpen && awaitBusy);
    checkOutput("err_timeout", err_timeout, errExp);
    checkOutput("tx_data_in", tx_data_in, lastWord);
    checkOutput("grant_id", grant_id, lastId);
    if (tx_valid_in === 1'b1) validHigh++;
    if (err_timeout === 1'b1) errCount++;
    if (req_ready != '0) readyCycles++;
    hs = req_valid & req_ready;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i] === 1'b1) grantLog.push_back(i);
    end
    txAcc = (tx_valid_in === 1'b1) && !busy && txAlive;
    txW   = tx_data_in;

    @(posedge clk);
    #1;

    errExp = 1'b0;
    if (w >= 0) begin
      jobOpen   = 1'b1;
      awaitBusy = 1'b1;
      issueAge  = 0;
      lastId    = w;
      lastWord  = reqWord[w];
      rrNext    = (w + 1) % NREQ;
    end else if (jobOpen && awaitBusy) begin
      if (busy) begin
        awaitBusy = 1'b0;
      end else if (issueAge == TIMEOUT - 1) begin
        jobOpen = 1'b0;
        errExp  = 1'b1;
      end else begin
        issueAge++;
      end
    end else if (jobOpen && !busy) begin
      jobOpen = 1'b0;
    end

    if (busyLeft > 0) busyLeft--;
    if (txAcc) begin
      busyLeft = busyLen;
      txLog.push_back(txW);
    end
    tx_busy_out = forceBusy || (busyLeft > 0);

    if (!holdValid) req_valid = req_valid & ~hs;
  endtask

  // Run until no job is open and nobody is requesting, within a cycle budget.
  task automatic drain(input int budget);
    int n;
    n = 0;
    do begin
      applyStimulus();
      n++;
    end while ((jobOpen || req_valid != '0) && n < budget);
    checkOutput("drain_budget", (jobOpen || req_valid != '0), 0);
  endtask

  task automatic clearLogs();
    txLog.delete();
    grantLog.delete();
    validHigh   = 0;
    errCount    = 0;
    readyCycles = 0;
  endtask

  initial begin
    int n;
    logic [DW-1:0] d1, d3, d1b;

    rst         = 1'b0;
    req_valid   = '0;
    req_data    = '0;
    tx_busy_out = 1'b0;
    holdValid   = 1'b0;
    txAlive     = 1'b1;
    forceBusy   = 1'b0;
    busyLen     = 6;
    busyLeft    = 0;
    for (int i = 0; i < NREQ; i++) reqWord[i] = '0;
    modelReset();
    clearLogs();

    // Reset values
    #2;
    checkOutput("rst_req_ready", req_ready, 0);
    checkOutput("rst_tx_valid", tx_valid_in, 0);
    checkOutput("rst_tx_data", tx_data_in, 0);
    checkOutput("rst_grant_id", grant_id, 0);
    checkOutput("rst_err", err_timeout, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // Single requester 2 with word 0xA, transmitter busy for 6 cycles
    setReq(2, 4'hA);
    #1;
    checkOutput("single_ready_comb", req_ready, 4'b0100);
    drain(60);
    checkOutput("single_grants", grantLog.size(), 1);
    if (grantLog.size() > 0) checkOutput("single_grant_idx", grantLog[0], 2);
    checkOutput("single_tx_jobs", txLog.size(), 1);
    if (txLog.size() > 0) checkOutput("single_tx_word", txLog[0], 4'hA);
    checkOutput("single_ready_cycles", readyCycles, 1);
    checkOutput("single_err", errCount, 0);
    checkOutput("single_grant_id", grant_id, 2);

    // Reset asserted while a word is being issued
    setReq(3, 4'h5);
    applyStimulus();
    checkOutput("pre_rst_valid", tx_valid_in, 1);
    rst = 1'b0;
    #1;
    checkOutput("midrst_tx_valid", tx_valid_in, 0);
    checkOutput("midrst_req_ready", req_ready, 0);
    checkOutput("midrst_err", err_timeout, 0);
    checkOutput("midrst_grant_id", grant_id, 0);
    req_valid   = '0;
    busyLeft    = 0;
    tx_busy_out = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // All four continuously valid with words 1..4: eight jobs in strict rotation
    clearLogs();
    busyLen   = 3;
    holdValid = 1'b1;
    for (int i = 0; i < NREQ; i++) setReq(i, DW'(i + 1));
    n = 0;
    while (txLog.size() < 8 && n < 300) begin
      applyStimulus();
      n++;
    end
    checkOutput("rr_tx_jobs", txLog.size(), 8);
    holdValid = 1'b0;
    req_valid = '0;
    drain(60);
    checkOutput("rr_grants", grantLog.size(), 8);
    for (int j = 0; j < 8 && j < grantLog.size(); j++) begin
      checkOutput("rr_grant_order", grantLog[j], j % NREQ);
    end
    for (int j = 0; j < 8 && j < txLog.size(); j++) begin
      checkOutput("rr_tx_word", txLog[j], (j % NREQ) + 1);
    end

    // Timeout on requester 1, then 3 then 1 again (pointer at 2, then wraps)
    clearLogs();
    d1  = DW'($urandom);
    d3  = DW'($urandom);
    d1b = DW'($urandom);
    txAlive = 1'b0;
    setReq(1, d1);
    setReq(3, d3);
    n = 0;
    while (errCount == 0 && n < 60) begin
      applyStimulus();
      n++;
    end
    checkOutput("to_err_seen", errCount, 1);
    checkOutput("to_valid_cycles", validHigh, TIMEOUT);
    txAlive = 1'b1;
    setReq(1, d1b);
    drain(80);
    checkOutput("to_err_single", errCount, 1);
    checkOutput("to_grants", grantLog.size(), 3);
    if (grantLog.size() == 3) begin
      checkOutput("to_grant0", grantLog[0], 1);
      checkOutput("to_grant1", grantLog[1], 3);
      checkOutput("to_grant2", grantLog[2], 1);
    end
    checkOutput("to_tx_jobs", txLog.size(), 2);
    if (txLog.size() == 2) begin
      checkOutput("to_tx0", txLog[0], d3);
      checkOutput("to_tx1", txLog[1], d1b);
    end

    // Busy held externally: no accept until it drops, then grant at once
    clearLogs();
    forceBusy   = 1'b1;
    tx_busy_out = 1'b1;
    setReq(0, DW'($urandom));
    repeat (5) applyStimulus();
    checkOutput("fb_no_ready", readyCycles, 0);
    forceBusy   = 1'b0;
    tx_busy_out = (busyLeft > 0);
    applyStimulus();
    checkOutput("fb_ready_first", readyCycles, 1);
    checkOutput("fb_grant_count", grantLog.size(), 1);
    drain(60);

    // Randomized traffic: requests come and go, busy length varies per job
    clearLogs();
    for (int c = 0; c < 400; c++) begin
      busyLen = $urandom_range(1, 5);
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i]) begin
          if ($urandom_range(0, 3) == 0) setReq(i, DW'($urandom));
        end else if ($urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      applyStimulus();
    end
    req_valid = '0;
    drain(60);
    checkOutput("rand_jobs_match", txLog.size(), grantLog.size());
    checkOutput("rand_no_err", errCount, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
